// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per cycle, followed by a single round/exception stage.
package fp_div_pkg;
    typedef enum logic [2:0] {IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero} round_values;
endpackage

module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter round_values round = IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        zero_f,
    output logic        inf_f,
    output logic        nan_f,
    output logic        tiny_f,
    output logic        huge_f,
    output logic        inexact_f
);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    typedef enum logic [1:0] {CL_ZERO, CL_INF, CL_NORM} cls_t;

    function automatic cls_t classify(input logic [7:0] e);
        if (e == 8'h00)      return CL_ZERO;
        else if (e == 8'hFF) return CL_INF;
        else                 return CL_NORM;
    endfunction

    function automatic logic round_up(input logic sgn, input logic g, input logic s, input logic lsb);
        case (round)
            IEEE_near: return g & (s | lsb);
            IEEE_zero: return 1'b0;
            IEEE_pinf: return ~sgn & (g | s);
            IEEE_ninf: return sgn & (g | s);
            near_up:   return g;
            away_zero: return g | s;
            default:   return 1'b0;
        endcase
    endfunction

    // Directed modes that push a result away from zero saturate to inf / min_norm.
    function automatic logic away_from_zero(input logic sgn);
        return (round == away_zero) || (round == IEEE_pinf && !sgn) || (round == IEEE_ninf && sgn);
    endfunction

    function automatic logic ovf_to_inf(input logic sgn);
        return (round == IEEE_near) || (round == near_up) || away_from_zero(sgn);
    endfunction

    // flags vector order: {zero, inf, nan, tiny, huge, inexact}
    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        z_q, z_d;
    logic [5:0]         flags_q, flags_d;
    logic               sign_q, sign_d;
    logic [23:0]        mb_q, mb_d;
    logic [25:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;

    cls_t               ca, cb;
    logic [25:0]        trial;
    logic               ge;
    logic [23:0]        man_r;
    logic               g_r, s_r, inc_r;
    logic signed [9:0]  exp_r, exp_f;
    logic [24:0]        man_sum;
    logic [23:0]        man_f;

    assign ca    = classify(a[30:23]);
    assign cb    = classify(b[30:23]);
    assign ge    = rem_q >= {2'b00, mb_q};
    assign trial = rem_q - {2'b00, mb_q};

    // Normalise the 26-bit quotient: q[25] set means the mantissa ratio was >= 1.
    assign man_r   = quo_q[25] ? quo_q[25:2] : quo_q[24:1];
    assign g_r     = quo_q[25] ? quo_q[1] : quo_q[0];
    assign s_r     = (quo_q[25] & quo_q[0]) | (rem_q != '0);
    assign exp_r   = quo_q[25] ? exp_q : exp_q - 10'sd1;
    assign inc_r   = round_up(sign_q, g_r, s_r, man_r[0]);
    assign man_sum = {1'b0, man_r} + {24'd0, inc_r};
    assign exp_f   = man_sum[24] ? exp_r + 10'sd1 : exp_r;
    assign man_f   = man_sum[24] ? 24'h800000 : man_sum[23:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        sign_d      = sign_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        exp_d       = exp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = a[31] ^ b[31];
                    flags_d = '0;
                    if (ca == CL_NORM && cb == CL_NORM) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        mb_d    = {1'b1, b[22:0]};
                        rem_d   = {2'b01, a[22:0]};
                        quo_d   = '0;
                        exp_d   = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        if ((ca == CL_ZERO && cb == CL_ZERO) || (ca == CL_INF && cb == CL_INF)) begin
                            z_d     = 32'h7F800000;
                            flags_d = 6'b011000;
                        end else if (cb == CL_ZERO || ca == CL_INF) begin
                            z_d     = {a[31] ^ b[31], 8'hFF, 23'd0};
                            flags_d = 6'b010000;
                        end else begin
                            z_d     = {a[31] ^ b[31], 31'd0};
                            flags_d = 6'b100000;
                        end
                    end
                end
            end
            DIV: begin
                quo_d = {quo_q[24:0], ge};
                rem_d = ge ? {trial[24:0], 1'b0} : {rem_q[24:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = ROUND;
            end
            ROUND: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                if (exp_f >= 10'sd255) begin
                    z_d     = ovf_to_inf(sign_q) ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7FFFFF};
                    flags_d = {1'b0, ovf_to_inf(sign_q), 1'b0, 1'b0, 1'b1, 1'b1};
                end else if (exp_f <= 10'sd0) begin
                    z_d     = away_from_zero(sign_q) ? {sign_q, 8'h01, 23'd0} : {sign_q, 31'd0};
                    flags_d = {!away_from_zero(sign_q), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
                end else begin
                    z_d     = {sign_q, exp_f[7:0], man_f[22:0]};
                    flags_d = {5'b00000, g_r | s_r};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        mb_q   <= mb_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        exp_q  <= exp_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign zero_f    = flags_q[5];
    assign inf_f     = flags_q[4];
    assign nan_f     = flags_q[3];
    assign tiny_f    = flags_q[2];
    assign huge_f    = flags_q[1];
    assign inexact_f = flags_q[0];

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: one instance per rounding mode driven in lockstep, directed
// table vectors, multi-cycle handshake/reset sequences and a randomized model comparison.
module tb_fp_div_seq;
    import fp_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [5:0]  in_ready_w;
    logic [5:0]  out_valid_w;
    logic [31:0] z_w [6];
    logic [5:0]  fl_w [6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 6; gi++) begin : g_dut
        fp_div_seq #(.round(round_values'(gi))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .a         (a_in),
            .b         (b_in),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .z         (z_w[gi]),
            .zero_f    (fl_w[gi][5]),
            .inf_f     (fl_w[gi][4]),
            .nan_f     (fl_w[gi][3]),
            .tiny_f    (fl_w[gi][2]),
            .huge_f    (fl_w[gi][1]),
            .inexact_f (fl_w[gi][0])
        );
    end

    typedef struct packed {
        logic [31:0] z;
        logic [5:0]  f;
        logic        special;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        logic [31:0] z;
        logic [5:0]  f;
    } vec_t;

    function automatic int cls(input logic [7:0] e);
        if (e == 8'h00) return 0;
        if (e == 8'hFF) return 1;
        return 2;
    endfunction

    // Value-level reference: exact integer quotient of the significands, rounded by mode.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input int mode);
        res_t        r;
        logic        sgn, g, s, up, ovf_inf, ufl_min;
        int          ca, cb, e;
        logic [63:0] ma, mb, num, m, rm;
        r.z = '0;
        r.f = '0;
        r.special = 1'b1;
        sgn = a[31] ^ b[31];
        ca = cls(a[30:23]);
        cb = cls(b[30:23]);
        if ((ca == 0 && cb == 0) || (ca == 1 && cb == 1)) begin
            r.z = 32'h7F800000; r.f = 6'b011000; return r;
        end
        if (cb == 0 || ca == 1) begin
            r.z = {sgn, 8'hFF, 23'd0}; r.f = 6'b010000; return r;
        end
        if (ca == 0 || cb == 1) begin
            r.z = {sgn, 31'd0}; r.f = 6'b100000; return r;
        end
        r.special = 1'b0;
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (ma >= mb) num = ma << 23;
        else begin
            num = ma << 24;
            e = e - 1;
        end
        m  = num / mb;
        rm = num % mb;
        g  = ((rm << 1) >= mb);
        s  = (rm != 0) && ((rm << 1) != mb);
        case (mode)
            0: up = g && (s || m[0]);
            1: up = 1'b0;
            2: up = !sgn && (g || s);
            3: up = sgn && (g || s);
            4: up = g;
            default: up = g || s;
        endcase
        if (up) m = m + 64'd1;
        if (m == 64'h1000000) begin
            m = 64'h800000;
            e = e + 1;
        end
        ufl_min = (mode == 5) || (mode == 2 && !sgn) || (mode == 3 && sgn);
        ovf_inf = (mode == 0) || (mode == 4) || ufl_min;
        if (e >= 255) begin
            r.z = ovf_inf ? {sgn, 8'hFF, 23'd0} : {sgn, 8'hFE, 23'h7FFFFF};
            r.f = {1'b0, ovf_inf, 1'b0, 1'b0, 1'b1, 1'b1};
        end else if (e <= 0) begin
            r.z = ufl_min ? {sgn, 8'h01, 23'd0} : {sgn, 31'd0};
            r.f = {!ufl_min, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        end else begin
            r.z = {sgn, e[7:0], m[22:0]};
            r.f = {5'b00000, g || s};
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] m;
        int          k;
        k = $urandom_range(0, 15);
        m = 23'($urandom);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else             e = 8'($urandom_range(1, 254));
        if (k == 2) m = m & 23'h7F0000;
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present operands for one accept edge, then count edges until out_valid (bounded).
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {26'd0, in_ready_w}, 32'h3F);
        a_in = av;
        b_in = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_w[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", {26'd0, out_valid_w}, 32'h0);
    endtask

    vec_t tbl[$];
    res_t exp_r;
    int   lat;

    initial begin
        tbl.push_back('{32'h40C00000, 32'h40000000, 0, 32'h40400000, 6'b000000});
        tbl.push_back('{32'h3F800000, 32'h40400000, 0, 32'h3EAAAAAB, 6'b000001});
        tbl.push_back('{32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAA, 6'b000001});
        tbl.push_back('{32'hBF800000, 32'h40400000, 3, 32'hBEAAAAAB, 6'b000001});
        tbl.push_back('{32'hBF800000, 32'h40400000, 2, 32'hBEAAAAAA, 6'b000001});
        tbl.push_back('{32'h00000000, 32'h00000000, 0, 32'h7F800000, 6'b011000});
        tbl.push_back('{32'hBF800000, 32'h00000000, 0, 32'hFF800000, 6'b010000});
        tbl.push_back('{32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 6'b011000});
        tbl.push_back('{32'h3F800000, 32'h7F800000, 0, 32'h00000000, 6'b100000});
        tbl.push_back('{32'h7F000000, 32'h3E800000, 0, 32'h7F800000, 6'b010011});
        tbl.push_back('{32'h7F000000, 32'h3E800000, 1, 32'h7F7FFFFF, 6'b000011});
        tbl.push_back('{32'h00800000, 32'h47000000, 0, 32'h00000000, 6'b100101});
        tbl.push_back('{32'h00800000, 32'h47000000, 5, 32'h00800000, 6'b000101});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", {26'd0, in_ready_w}, 32'h3F);
        chk("reset_out_valid", {26'd0, out_valid_w}, 32'h0);
        chk("reset_z", z_w[0], 32'h0);
        chk("reset_flags", {26'd0, fl_w[0]}, 32'h0);

        foreach (tbl[i]) begin
            start_op(tbl[i].a, tbl[i].b, lat);
            exp_r = model(tbl[i].a, tbl[i].b, 0);
            chk($sformatf("vec%0d_latency", i), lat, exp_r.special ? 32'd1 : 32'd28);
            chk($sformatf("vec%0d_z", i), z_w[tbl[i].mode], tbl[i].z);
            chk($sformatf("vec%0d_flags", i), {26'd0, fl_w[tbl[i].mode]}, {26'd0, tbl[i].f});
            finish_op();
        end

        // Result held while the consumer stalls.
        start_op(32'h40C00000, 32'h40000000, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'd0, out_valid_w[0]}, 32'h1);
            chk("hold_z", z_w[0], 32'h40400000);
            chk("hold_flags", {26'd0, fl_w[0]}, 32'h0);
        end
        finish_op();

        // in_valid while busy is ignored; the first operand pair still completes.
        @(negedge clk);
        a_in = 32'h40C00000;
        b_in = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_in_ready", {26'd0, in_ready_w}, 32'h0);
        a_in = 32'h3F800000;
        b_in = 32'h40400000;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 8;
        while (!out_valid_w[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_latency", lat, 32'd28);
        chk("busy_z", z_w[0], 32'h40400000);
        finish_op();

        // Reset in the middle of a division aborts it.
        @(negedge clk);
        a_in = 32'h3F800000;
        b_in = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {26'd0, out_valid_w}, 32'h0);
        chk("midrst_in_ready", {26'd0, in_ready_w}, 32'h3F);
        chk("midrst_z", z_w[0], 32'h0);
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_late_result", {26'd0, out_valid_w}, 32'h0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra, rb;
            ra = rnd_fp();
            rb = rnd_fp();
            start_op(ra, rb, lat);
            exp_r = model(ra, rb, 0);
            chk($sformatf("rnd%0d_latency a=%h b=%h", n, ra, rb), lat, exp_r.special ? 32'd1 : 32'd28);
            for (int md = 0; md < 6; md++) begin
                exp_r = model(ra, rb, md);
                chk($sformatf("rnd%0d_m%0d_z a=%h b=%h", n, md, ra, rb), z_w[md], exp_r.z);
                chk($sformatf("rnd%0d_m%0d_flags a=%h b=%h", n, md, ra, rb), {26'd0, fl_w[md]}, {26'd0, exp_r.f});
            end
            finish_op();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
